// File: rtl/mul_job_scheduler_if.sv
// Bundles the requester, response and multiplier-core signals of mul_job_scheduler.
// slave is the scheduler's view; master is the view of everything around it.
interface mul_job_scheduler_if #(
    parameter int OP_W  = 17669,
    parameter int RES_W = 35338
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [OP_W-1:0]  req0_u;
    logic [OP_W-1:0]  req0_v;
    logic [OP_W-1:0]  req1_u;
    logic [OP_W-1:0]  req1_v;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [RES_W-1:0] rsp_data;
    logic             rsp_error;
    logic             mul_rst;
    logic [OP_W-1:0]  mul_u;
    logic [OP_W-1:0]  mul_v;
    logic [RES_W-1:0] mul_w;
    logic             mul_done;

    modport slave (
        input  req_valid, req0_u, req0_v, req1_u, req1_v, rsp_ready, mul_w, mul_done,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_error, mul_rst, mul_u, mul_v
    );

    modport master (
        output req_valid, req0_u, req0_v, req1_u, req1_v, rsp_ready, mul_w, mul_done,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_error, mul_rst, mul_u, mul_v
    );
endinterface

// File: rtl/mul_job_scheduler.sv
// Round-robin job scheduler in front of one sequential multiplier core:
// grant, load operands, run with timeout, then return the tagged product.
module mul_job_scheduler #(
    parameter int OP_W    = 17669,
    parameter int RES_W   = 35338,
    parameter int TIMEOUT = 65535,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    mul_job_scheduler_if.slave   bus,
    output logic [1:0]           dbg_state
);
    // Handshakes: a request transfers when req_valid[g] & req_ready[g] at a rising
    // edge; a response transfers when rsp_valid & rsp_ready. Valid never waits on ready.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             id_q, id_d;
    logic [RES_W-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_error_q, rsp_error_d;
    logic             mul_rst_q, mul_rst_d;
    logic [OP_W-1:0]  mul_u_q, mul_u_d;
    logic [OP_W-1:0]  mul_v_q, mul_v_d;
    logic             gnt;
    logic [1:0]       req_ready_c;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        rsp_data_d   = rsp_data_q;
        rsp_error_d  = rsp_error_q;
        mul_u_d      = mul_u_q;
        mul_v_d      = mul_v_q;
        req_ready_c  = 2'b00;
        // On a tie the requester that did not win last time goes next.
        gnt = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];

        case (state_q)
            IDLE: begin
                if ((|bus.req_valid) && reset) begin
                    req_ready_c  = gnt ? 2'b10 : 2'b01;
                    state_d      = LOAD;
                    id_d         = gnt;
                    last_grant_d = gnt;
                    mul_u_d      = gnt ? bus.req1_u : bus.req0_u;
                    mul_v_d      = gnt ? bus.req1_v : bus.req0_v;
                end
            end
            LOAD: begin
                // mul_done here still reflects the previous job, so it is not looked at.
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.mul_done) begin
                    rsp_data_d  = bus.mul_w;
                    rsp_error_d = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_data_d  = '0;
                    rsp_error_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        mul_rst_d = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            rsp_data_q   <= '0;
            rsp_error_q  <= 1'b0;
            mul_rst_q    <= 1'b1;
            mul_u_q      <= '0;
            mul_v_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_error_q  <= rsp_error_d;
            mul_rst_q    <= mul_rst_d;
            mul_u_q      <= mul_u_d;
            mul_v_q      <= mul_v_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.mul_rst   = mul_rst_q;
    assign bus.mul_u     = mul_u_q;
    assign bus.mul_v     = mul_v_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_mul_job_scheduler.sv
// Bench for mul_job_scheduler with a behavioural multiplier core that raises
// mul_done core_n cycles after mul_rst falls.
module tb_mul_job_scheduler;
  logic clk;
  logic reset;
  logic [1:0] dbg_state;
  int n_checks;
  int n_fail;
  int cyc;

  // core model controls
  int   core_n;
  logic core_never;
  logic stale_done;
  logic [7:0] core_cnt;

  logic [17:0] exp_q[$];

  mul_job_scheduler_if #(.OP_W(8), .RES_W(16)) bus ();

  mul_job_scheduler #(.OP_W(8), .RES_W(16), .TIMEOUT(10), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.mul_rst) core_cnt <= 8'd0;
    else if (core_cnt != 8'hFF) core_cnt <= core_cnt + 8'd1;
  end
  assign bus.mul_done = stale_done | (!core_never && !bus.mul_rst && (int'(core_cnt) >= core_n));
  assign bus.mul_w    = 16'(bus.mul_u) * 16'(bus.mul_v);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
    $fatal(1, "watchdog");
  end

  // driver tasks: entered just after a falling edge
  task automatic issue(input logic [1:0] vm, input logic [7:0] u, input logic [7:0] v,
                       output int hs, output int g, output int start);
    bus.req_valid = vm;
    bus.req0_u = u; bus.req0_v = v;
    bus.req1_u = u; bus.req1_v = v;
    start = cyc;
    hs = -1;
    g = -1;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (|bus.req_ready) begin
        hs = cyc;
        g = bus.req_ready[1] ? 1 : 0;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
  endtask

  task automatic wait_rsp(output int rc);
    rc = -1;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (bus.rsp_valid) begin
        rc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    bus.req0_u = 8'h12; bus.req0_v = 8'h34;
    bus.req1_u = 8'h56; bus.req1_v = 8'h78;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b required 00", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_id !== 1'b0 || bus.rsp_error !== 1'b0 || bus.rsp_data !== 16'h0) begin
      n_fail++; $display("FAIL reset_rsp_fields: got id=%b err=%b data=%h required 0/0/0000", bus.rsp_id, bus.rsp_error, bus.rsp_data); end
    n_checks++; if (bus.mul_rst !== 1'b1) begin n_fail++; $display("FAIL reset_mul_rst: got %b required 1", bus.mul_rst); end
    n_checks++; if (bus.mul_u !== 8'h0 || bus.mul_v !== 8'h0) begin n_fail++; $display("FAIL reset_mul_uv: got %h/%h required 00/00", bus.mul_u, bus.mul_v); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
    bus.req_valid = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int grants, rsps, exp_g, g;
    logic [17:0] e;
    logic [15:0] p0, p1;
    grants = 0; rsps = 0; exp_g = 0;
    core_n = 2;
    bus.rsp_ready = 1'b1;
    bus.req0_u = 8'($urandom_range(0, 255)); bus.req0_v = 8'($urandom_range(0, 255));
    bus.req1_u = 8'($urandom_range(0, 255)); bus.req1_v = 8'($urandom_range(0, 255));
    bus.req_valid = 2'b11;
    for (int c = 0; c < 300 && rsps < 4; c++) begin
      #1;
      n_checks++; if (bus.req_ready === 2'b11) begin n_fail++; $display("FAIL cont_onehot: got req_ready=%b required not 11", bus.req_ready); end
      if (|bus.req_ready) begin
        g = bus.req_ready[1] ? 1 : 0;
        n_checks++; if (g != exp_g) begin n_fail++; $display("FAIL cont_grant_order: got %0d required %0d (grant %0d)", g, exp_g, grants); end
        p0 = 16'(bus.req0_u) * 16'(bus.req0_v);
        p1 = 16'(bus.req1_u) * 16'(bus.req1_v);
        exp_q.push_back({exp_g[0], 1'b0, exp_g[0] ? p1 : p0});
        exp_g = 1 - exp_g;
        grants++;
      end
      if (bus.rsp_valid) begin
        e = exp_q.pop_front();
        n_checks++; if ({bus.rsp_id, bus.rsp_error, bus.rsp_data} !== e) begin
          n_fail++; $display("FAIL cont_rsp: got id=%b err=%b data=%h required id=%b err=%b data=%h", bus.rsp_id, bus.rsp_error, bus.rsp_data, e[17], e[16], e[15:0]); end
        rsps++;
      end
      @(negedge clk);
      if (grants >= 4) bus.req_valid = 2'b00;
      bus.req0_u = 8'($urandom_range(0, 255)); bus.req0_v = 8'($urandom_range(0, 255));
      bus.req1_u = 8'($urandom_range(0, 255)); bus.req1_v = 8'($urandom_range(0, 255));
    end
    bus.req_valid = 2'b00;
    n_checks++; if (rsps != 4) begin n_fail++; $display("FAIL cont_count: got %0d responses required 4", rsps); end
    exp_q.delete();
  endtask

  task automatic test_single_job();
    int hs, g, st, rc;
    logic [17:0] e;
    core_n = 5;
    bus.rsp_ready = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 16'h002D});
    issue(2'b01, 8'h0F, 8'h03, hs, g, st);
    n_checks++; if (hs != st || g != 0) begin n_fail++; $display("FAIL single_ready: got hs_cyc=%0d grant=%0d required %0d/0", hs, g, st); end
    wait_rsp(rc);
    n_checks++; if (rc - hs != 8) begin n_fail++; $display("FAIL single_latency: got %0d required 8", rc - hs); end
    e = exp_q.pop_front();
    n_checks++; if ({bus.rsp_id, bus.rsp_error, bus.rsp_data} !== e) begin
      n_fail++; $display("FAIL single_rsp: got id=%b err=%b data=%h required id=%b err=%b data=%h", bus.rsp_id, bus.rsp_error, bus.rsp_data, e[17], e[16], e[15:0]); end
    n_checks++; if (bus.mul_u !== 8'h0F || bus.mul_v !== 8'h03) begin n_fail++; $display("FAIL single_mul_uv_hold: got %h/%h required 0f/03", bus.mul_u, bus.mul_v); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int hs, g, st, rc;
    logic [17:0] e;
    core_n = 1;
    bus.rsp_ready = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 16'(8'hA5) * 16'(8'h3C)});
    issue(2'b10, 8'hA5, 8'h3C, hs, g, st);
    bus.req_valid = 2'b11;
    wait_rsp(rc);
    e = exp_q.pop_front();
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (bus.rsp_valid !== 1'b1 || {bus.rsp_id, bus.rsp_error, bus.rsp_data} !== e) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b id=%b err=%b data=%h required v=1 id=%b err=%b data=%h", i, bus.rsp_valid, bus.rsp_id, bus.rsp_error, bus.rsp_data, e[17], e[16], e[15:0]); end
      n_checks++; if (bus.req_ready !== 2'b00 || bus.mul_rst !== 1'b1) begin
        n_fail++; $display("FAIL bp_ctrl[%0d]: got req_ready=%b mul_rst=%b required 00/1", i, bus.req_ready, bus.mul_rst); end
      @(negedge clk);
      #1;
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got rsp_valid=%b required 0", bus.rsp_valid); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int hs, g, st, rc;
    logic [17:0] e;
    core_never = 1'b1;
    bus.rsp_ready = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 16'h0000});
    issue(2'b01, 8'h77, 8'h11, hs, g, st);
    wait_rsp(rc);
    n_checks++; if (rc - hs != 12) begin n_fail++; $display("FAIL timeout_latency: got %0d required 12", rc - hs); end
    e = exp_q.pop_front();
    n_checks++; if ({bus.rsp_id, bus.rsp_error, bus.rsp_data} !== e) begin
      n_fail++; $display("FAIL timeout_rsp: got id=%b err=%b data=%h required id=%b err=%b data=%h", bus.rsp_id, bus.rsp_error, bus.rsp_data, e[17], e[16], e[15:0]); end
    @(negedge clk);
    core_never = 1'b0;
    core_n = 3;
    exp_q.push_back({1'b0, 1'b0, 16'(8'hC8) * 16'(8'h09)});
    issue(2'b01, 8'hC8, 8'h09, hs, g, st);
    wait_rsp(rc);
    n_checks++; if (rc - hs != 6) begin n_fail++; $display("FAIL after_timeout_latency: got %0d required 6", rc - hs); end
    e = exp_q.pop_front();
    n_checks++; if ({bus.rsp_id, bus.rsp_error, bus.rsp_data} !== e) begin
      n_fail++; $display("FAIL after_timeout_rsp: got id=%b err=%b data=%h required id=%b err=%b data=%h", bus.rsp_id, bus.rsp_error, bus.rsp_data, e[17], e[16], e[15:0]); end
    @(negedge clk);
  endtask

  task automatic test_stale_done();
    int hs, g, st, rc;
    logic [17:0] e;
    stale_done = 1'b1;
    bus.rsp_ready = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 16'(8'hFF) * 16'(8'hFE)});
    issue(2'b10, 8'hFF, 8'hFE, hs, g, st);
    wait_rsp(rc);
    stale_done = 1'b0;
    n_checks++; if (rc - hs != 3) begin n_fail++; $display("FAIL stale_latency: got %0d required 3", rc - hs); end
    e = exp_q.pop_front();
    n_checks++; if ({bus.rsp_id, bus.rsp_error, bus.rsp_data} !== e) begin
      n_fail++; $display("FAIL stale_rsp: got id=%b err=%b data=%h required id=%b err=%b data=%h", bus.rsp_id, bus.rsp_error, bus.rsp_data, e[17], e[16], e[15:0]); end
    @(negedge clk);
  endtask

  task automatic test_reset_in_run();
    int hs, g, st, rc, seen;
    logic [17:0] e;
    core_n = 5;
    bus.rsp_ready = 1'b1;
    issue(2'b01, 8'h21, 8'h43, hs, g, st);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.mul_rst !== 1'b1 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL rir_ctrl: got rsp_valid=%b mul_rst=%b state=%0d required 0/1/0", bus.rsp_valid, bus.mul_rst, dbg_state); end
    n_checks++; if (bus.mul_u !== 8'h0 || bus.mul_v !== 8'h0 || bus.rsp_data !== 16'h0 || bus.rsp_id !== 1'b0 || bus.rsp_error !== 1'b0) begin
      n_fail++; $display("FAIL rir_regs: got u=%h v=%h data=%h id=%b err=%b required all 0", bus.mul_u, bus.mul_v, bus.rsp_data, bus.rsp_id, bus.rsp_error); end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (bus.rsp_valid) seen++;
      @(negedge clk);
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rir_no_rsp: got %0d rsp_valid cycles required 0", seen); end
    exp_q.push_back({1'b1, 1'b0, 16'(8'h9B) * 16'(8'h64)});
    issue(2'b10, 8'h9B, 8'h64, hs, g, st);
    n_checks++; if (g != 1 || hs != st) begin n_fail++; $display("FAIL rir_grant: got grant=%0d hs_cyc=%0d required 1/%0d", g, hs, st); end
    wait_rsp(rc);
    n_checks++; if (rc - hs != 8) begin n_fail++; $display("FAIL rir_latency: got %0d required 8", rc - hs); end
    e = exp_q.pop_front();
    n_checks++; if ({bus.rsp_id, bus.rsp_error, bus.rsp_data} !== e) begin
      n_fail++; $display("FAIL rir_rsp: got id=%b err=%b data=%h required id=%b err=%b data=%h", bus.rsp_id, bus.rsp_error, bus.rsp_data, e[17], e[16], e[15:0]); end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    core_n = 5;
    core_never = 1'b0;
    stale_done = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    bus.req0_u = 8'h0; bus.req0_v = 8'h0;
    bus.req1_u = 8'h0; bus.req1_v = 8'h0;
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_contention();
    test_single_job();
    test_backpressure();
    test_timeout();
    test_stale_done();
    test_reset_in_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_job_scheduler.md
# mul_job_scheduler

Sequencing and sharing controller for the sequential polynomial multiplier core (the Toom-4 4460-limb datapath behind the 17669-bit wrapper). Accepts multiply jobs from two independent requesters and grants them round-robin. For each granted job it latches the operands and drives the core's start/hold control, waits for its done flag with a timeout, then returns the tagged product through a valid/ready response port. Sits between the requesting engines and a single multiplier instance.

## Interface
- OP_W, 17669, operand width in bits (core U/V width)
- RES_W, 35338, product width; must equal 2*OP_W
- TIMEOUT, 65535, max RUN cycles before a job is aborted; must be ≥ 2
- CNT_W, 16, timeout counter width; must satisfy 2^CNT_W > TIMEOUT
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester job valid
- req_ready  out  2  per-requester accept; at most one bit high
- req0_u, req0_v  in  OP_W each  requester 0 operands
- req1_u, req1_v  in  OP_W each  requester 1 operands
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  1  requester index of the response
- rsp_data  out  RES_W  product; 0 when rsp_error=1
- rsp_error  out  1  job aborted on timeout
- mul_rst  out  1  core hold/start, active-high; low means the core computes
- mul_u, mul_v  out  OP_W each  registered operands to core
- mul_w  in  RES_W  core product
- mul_done  in  1  core completion flag

## Operation
- States: IDLE, LOAD, RUN, RESP.
- IDLE:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester other than last_grant.
  - req_ready[g] is combinational: high only in IDLE for the granted g.
  - A handshake (valid & ready) latches the operands into mul_u/mul_v, records id=g, sets last_grant=g, and moves to LOAD.
- LOAD:
  - mul_rst stays high so the core resets with stable operands.
  - mul_done is ignored (stale from the previous job).
  - Always moves to RUN next cycle; counter cleared.
- RUN:
  - mul_rst low; counter increments every cycle.
  - If mul_done=1: capture mul_w into rsp_data, rsp_error=0, go to RESP.
  - Else if counter == TIMEOUT-1: rsp_data=0, rsp_error=1, go to RESP.
  - If done and timeout coincide, done wins (no error).
- RESP:
  - rsp_valid=1; mul_rst high again.
  - rsp_id, rsp_data and rsp_error are held stable until rsp_ready=1.
  - On accept, move to IDLE.
- No new request is accepted before the response has been accepted (single job in flight).
- mul_u/mul_v are held from LOAD through RESP; they change only on a new handshake.
- Reset (async, any state): state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_error=0, mul_rst=1, mul_u=0, mul_v=0, counter=0, last_grant=1 (so requester 0 wins the first tie).
- Reset asserted mid-job drops that job silently; no response is produced.

## Timing
- Handshake in cycle T → LOAD in T+1 → RUN from T+2 (first cycle with mul_rst=0).
- If mul_done is first sampled high in RUN cycle T+2+k, rsp_valid is high from T+3+k.
- Minimum job-to-response latency: 3 cycles. Timeout response: T+2+TIMEOUT.
- Back-to-back: with rsp_ready held high, RESP lasts 1 cycle, and the next handshake can occur the cycle after returning to IDLE.
- Minimum issue spacing is therefore 4 + core latency.
- mul_rst is registered; mul_rst=1 for at least the LOAD cycle before every run.

## Test plan
Benches use OP_W=8, RES_W=16, TIMEOUT=10 and a behavioral core model that raises mul_done N cycles after mul_rst falls.
- Single job: req0 u=0x0F, v=0x03, core N=5 → req_ready[0] in the same cycle; rsp_valid 8 cycles after the handshake; rsp_id=0, rsp_data=0x002D, rsp_error=0.
- Contention: both requesters valid continuously, 4 jobs → grants alternate 0,1,0,1; each rsp_id matches its grant order; req_ready is never 2'b11.
- Backpressure: rsp_ready low for 6 cycles in RESP → rsp_valid, rsp_data and rsp_id stable for all 6 cycles; req_ready stays 0; mul_rst=1.
- Timeout: core never asserts done → rsp_error=1 and rsp_data=0 exactly 12 cycles after the handshake; the next job then completes normally.
- Stale done: mul_done held high across LOAD → ignored in LOAD; product captured only in the first RUN cycle, so response latency is 3.
- Reset in RUN: reset pulsed low mid-job → all outputs at reset values immediately; no rsp_valid afterwards; a new req1 job is accepted and completes correctly.
